// File: rtl/mb_tx_sched_pkg.sv
// Shared types and constants for the mainband transmit flit scheduler.
package mb_tx_sched_pkg;

   localparam int unsigned FLIT_BYTES = 64;
   localparam int unsigned GNT_ID_W   = 3;

   typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

   typedef enum logic [1:0] {
      DISABLED,
      IDLE,
      GAP
   } state_e;

endpackage

// File: rtl/mb_tx_flit_scheduler_if.sv
// Requester / transmitter signal bundle for the flit scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface mb_tx_flit_scheduler_if #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned FLIT_BUFS = 2
);

   localparam int unsigned CW = $clog2(FLIT_BUFS) + 1;

   logic                                          tx_enable_i;
   logic [NUM_REQ-1:0]                            req_valid_i;
   mb_tx_sched_pkg::flit_t [NUM_REQ-1:0]          req_data_i;
   logic [NUM_REQ-1:0]                            req_ready_o;
   logic                                          transmiting_i;
   logic                                          valid_o;
   mb_tx_sched_pkg::flit_t                        data_o;
   logic [mb_tx_sched_pkg::GNT_ID_W-1:0]          grant_id_o;
   logic [CW-1:0]                                 credits_o;
   logic                                          tx_idle_o;
   logic                                          err_o;
   logic [15:0]                                   flits_sent_o;

   modport master (
      input  tx_enable_i, req_valid_i, req_data_i, transmiting_i,
      output req_ready_o, valid_o, data_o, grant_id_o, credits_o, tx_idle_o, err_o,
             flits_sent_o
   );

   modport slave (
      output tx_enable_i, req_valid_i, req_data_i, transmiting_i,
      input  req_ready_o, valid_o, data_o, grant_id_o, credits_o, tx_idle_o, err_o,
             flits_sent_o
   );

endinterface

// File: rtl/mb_tx_rr_arbiter.sv
// Combinational round-robin pick over requesters 1..NUM_REQ-1, starting at ptr.
// Requester 0 is never considered here.
module mb_tx_rr_arbiter
   import mb_tx_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [GNT_ID_W-1:0] ptr,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [GNT_ID_W-1:0] idx,
   output logic                found
);

   localparam int unsigned IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   int unsigned cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
         // ptr lives in 1..NUM_REQ-1; map ptr+off back into that range
         cand = 1 + (32'(ptr) + off + NUM_REQ - 2) % (NUM_REQ - 1);
         if (!found && req[cand[IW-1:0]]) begin
            found               = 1'b1;
            gnt[cand[IW-1:0]]   = 1'b1;
            idx                 = GNT_ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mb_tx_flit_scheduler.sv
// Shares one 64-byte flit path to the mainband transmitter between NUM_REQ requesters,
// with strict priority for requester 0 and credit-based pacing of the transmitter buffer.
module mb_tx_flit_scheduler
   import mb_tx_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned FLIT_BUFS = 2,
   parameter int unsigned MIN_GAP   = 2
) (
   input logic                   clk_100MHz,
   input logic                   reset,
   mb_tx_flit_scheduler_if.master bus
);

   localparam int unsigned CW = $clog2(FLIT_BUFS) + 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFS);

   state_e                state_q;
   logic [CW-1:0]         credits_q;
   logic [GNT_ID_W-1:0]   rr_ptr_q;
   logic [3:0]            gap_cnt_q;
   logic                  err_q;
   logic [15:0]           flits_q;
   logic                  valid_q;
   flit_t                 data_q;
   logic [GNT_ID_W-1:0]   grant_id_q;
   logic [2:0]            sync_q;

   logic                  grant_ok;
   logic                  issue;
   logic                  ret;
   logic [NUM_REQ-1:0]    req_ready;
   logic [GNT_ID_W-1:0]   win;
   flit_t                 sel_data;
   logic [NUM_REQ-1:0]    rr_req;
   logic [NUM_REQ-1:0]    rr_gnt;
   logic [GNT_ID_W-1:0]   rr_idx;
   logic                  rr_found;

   // sync_q[1] is the synchronized busy flag, sync_q[2] its previous value
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], bus.transmiting_i};
      end
   end

   assign ret    = sync_q[2] & ~sync_q[1];
   assign rr_req = {bus.req_valid_i[NUM_REQ-1:1], 1'b0};

   mb_tx_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req   (rr_req),
      .ptr   (rr_ptr_q),
      .gnt   (rr_gnt),
      .idx   (rr_idx),
      .found (rr_found)
   );

   assign grant_ok = (state_q == IDLE) && bus.tx_enable_i && (credits_q != '0);

   always_comb begin
      req_ready = '0;
      win       = '0;
      sel_data  = '0;
      if (grant_ok) begin
         if (bus.req_valid_i[0]) begin
            req_ready[0] = 1'b1;
         end else if (rr_found) begin
            req_ready = rr_gnt;
            win       = rr_idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) sel_data = bus.req_data_i[i];
      end
   end

   assign issue = |req_ready;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q    <= DISABLED;
         credits_q  <= CRED_MAX;
         rr_ptr_q   <= GNT_ID_W'(1);
         gap_cnt_q  <= '0;
         err_q      <= 1'b0;
         flits_q    <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         grant_id_q <= '0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            DISABLED: begin
               if (bus.tx_enable_i) state_q <= IDLE;
            end
            IDLE: begin
               if (!bus.tx_enable_i) begin
                  state_q <= DISABLED;
               end else if (issue) begin
                  state_q    <= GAP;
                  gap_cnt_q  <= 4'(MIN_GAP - 1);
                  valid_q    <= 1'b1;
                  data_q     <= sel_data;
                  grant_id_q <= win;
                  flits_q    <= flits_q + 16'd1;
                  if (win != '0) begin
                     rr_ptr_q <= (win == GNT_ID_W'(NUM_REQ - 1)) ? GNT_ID_W'(1) : win + 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q <= bus.tx_enable_i ? IDLE : DISABLED;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            default: state_q <= DISABLED;
         endcase

         if (issue && !ret) begin
            credits_q <= credits_q - 1'b1;
         end else if (ret && !issue) begin
            // a return with every buffer already free means the transmitter misbehaved
            if (credits_q == CRED_MAX) err_q <= 1'b1;
            else                       credits_q <= credits_q + 1'b1;
         end
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.valid_o      = valid_q;
   assign bus.data_o       = data_q;
   assign bus.grant_id_o   = grant_id_q;
   assign bus.credits_o    = credits_q;
   assign bus.err_o        = err_q;
   assign bus.flits_sent_o = flits_q;
   assign bus.tx_idle_o    = (credits_q == CRED_MAX) && (state_q != GAP) && !valid_q &&
                             !sync_q[1];

endmodule

// File: tb/tb_mb_tx_flit_scheduler.sv
// Directed bench for mb_tx_flit_scheduler with NUM_REQ=3, FLIT_BUFS=2, MIN_GAP=2.
module tb_mb_tx_flit_scheduler;
   import mb_tx_sched_pkg::*;

   logic clk_100MHz = 1'b0;
   logic reset      = 1'b1;
   int   checks     = 0;
   int   errors     = 0;

   logic [7:0] pat [3] = '{8'h3C, 8'hA5, 8'h5A};

   mb_tx_flit_scheduler_if #(.NUM_REQ(3), .FLIT_BUFS(2)) bus ();

   mb_tx_flit_scheduler #(
      .NUM_REQ   (3),
      .FLIT_BUFS (2),
      .MIN_GAP   (2)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .bus        (bus)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   function automatic flit_t flit_of(input logic [7:0] b);
      flit_t f;
      for (int i = 0; i < FLIT_BYTES; i++) f[i] = b;
      return f;
   endfunction

   task automatic return_credit();
      bus.transmiting_i = 1'b1;
      tick();
      bus.transmiting_i = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %0b expected 0", bus.valid_o);
      end
      checks++;
      if (bus.credits_o !== 2'd2) begin
         errors++; $display("FAIL reset_credits: got %0d expected 2", bus.credits_o);
      end
      checks++;
      if (bus.err_o !== 1'b0 || bus.flits_sent_o !== 16'd0 || bus.grant_id_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_counters: got err=%0b flits=%0d gid=%0d expected 0 0 0",
                  bus.err_o, bus.flits_sent_o, bus.grant_id_o);
      end
      checks++;
      if (bus.req_ready_o !== 3'b000 || bus.tx_idle_o !== 1'b1 || bus.data_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b idle=%0b expected 000 1",
                  bus.req_ready_o, bus.tx_idle_o);
      end
   endtask

   task automatic test_single_issue();
      bus.tx_enable_i = 1'b1;
      bus.req_valid_i = 3'b010;
      #1;
      checks++;
      if (bus.req_ready_o !== 3'b000) begin
         errors++; $display("FAIL disabled_ready: got %b expected 000", bus.req_ready_o);
      end
      tick();
      checks++;
      if (bus.req_ready_o !== 3'b010) begin
         errors++; $display("FAIL first_grant: got %b expected 010", bus.req_ready_o);
      end
      tick();
      bus.req_valid_i = 3'b000;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.grant_id_o !== 3'd1) begin
         errors++;
         $display("FAIL first_issue: got valid=%0b gid=%0d expected 1 1",
                  bus.valid_o, bus.grant_id_o);
      end
      checks++;
      if (bus.data_o !== flit_of(8'hA5)) begin
         errors++; $display("FAIL first_data: got %h expected all a5", bus.data_o);
      end
      checks++;
      if (bus.credits_o !== 2'd1 || bus.flits_sent_o !== 16'd1) begin
         errors++;
         $display("FAIL first_counts: got credits=%0d flits=%0d expected 1 1",
                  bus.credits_o, bus.flits_sent_o);
      end
      tick();
      checks++;
      if (bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL valid_one_cycle: got %0b expected 0", bus.valid_o);
      end
      return_credit();
      checks++;
      if (bus.credits_o !== 2'd2 || bus.tx_idle_o !== 1'b1) begin
         errors++;
         $display("FAIL first_return: got credits=%0d idle=%0b expected 2 1",
                  bus.credits_o, bus.tx_idle_o);
      end
   endtask

   task automatic test_arbitration();
      logic [2:0] exp_ids [7] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd2, 3'd1};
      int n    = 0;
      int cyc  = 0;
      int last = 0;
      bus.req_valid_i = 3'b111;
      while (n < 7 && cyc < 80) begin
         tick();
         cyc++;
         if (bus.transmiting_i) bus.transmiting_i = 1'b0;
         if (bus.valid_o) begin
            checks++;
            if (bus.grant_id_o !== exp_ids[n]) begin
               errors++;
               $display("FAIL arb_order[%0d]: got %0d expected %0d", n, bus.grant_id_o,
                        exp_ids[n]);
            end
            checks++;
            if (bus.data_o !== flit_of(pat[exp_ids[n]])) begin
               errors++; $display("FAIL arb_data[%0d]: got %h", n, bus.data_o);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last != 3) begin
                  errors++; $display("FAIL arb_spacing[%0d]: got %0d expected 3", n, cyc - last);
               end
            end
            last = cyc;
            bus.transmiting_i = 1'b1;
            n++;
            if (n == 3) bus.req_valid_i = 3'b110;
         end
      end
      checks++;
      if (n != 7) begin
         errors++; $display("FAIL arb_count: got %0d expected 7", n);
      end
      bus.req_valid_i = 3'b000;
      tick();
      bus.transmiting_i = 1'b0;
      repeat (6) tick();
      checks++;
      if (bus.credits_o !== 2'd2 || bus.err_o !== 1'b0) begin
         errors++;
         $display("FAIL arb_credits: got credits=%0d err=%0b expected 2 0",
                  bus.credits_o, bus.err_o);
      end
   endtask

   task automatic test_credit_exhaust();
      int   issues   = 0;
      int   w        = 0;
      logic seen_rdy = 1'b0;
      logic got      = 1'b0;
      bus.req_valid_i = 3'b010;
      repeat (20) begin
         tick();
         if (bus.valid_o) issues++;
         if (issues >= 2 && !bus.valid_o) seen_rdy |= |bus.req_ready_o;
      end
      checks++;
      if (issues != 2 || bus.credits_o !== 2'd0) begin
         errors++;
         $display("FAIL exhaust: got issues=%0d credits=%0d expected 2 0", issues, bus.credits_o);
      end
      checks++;
      if (seen_rdy !== 1'b0) begin
         errors++; $display("FAIL exhaust_ready: got %0b expected 0", seen_rdy);
      end
      bus.transmiting_i = 1'b1;
      tick();
      bus.transmiting_i = 1'b0;
      while (!got && w < 6) begin
         tick();
         w++;
         if (bus.credits_o === 2'd1) got = 1'b1;
      end
      checks++;
      if (!got || w < 2 || w > 3) begin
         errors++; $display("FAIL exhaust_return: got credit=%0b after %0d expected 2..3", got, w);
      end
      got = 1'b0;
      w   = 0;
      while (!got && w < 5) begin
         tick();
         w++;
         if (bus.valid_o) got = 1'b1;
      end
      bus.req_valid_i = 3'b000;
      checks++;
      if (!got || bus.grant_id_o !== 3'd1 || bus.credits_o !== 2'd0) begin
         errors++;
         $display("FAIL exhaust_reissue: got issued=%0b gid=%0d credits=%0d expected 1 1 0",
                  got, bus.grant_id_o, bus.credits_o);
      end
      return_credit();
      return_credit();
      checks++;
      if (bus.credits_o !== 2'd2) begin
         errors++; $display("FAIL exhaust_restore: got %0d expected 2", bus.credits_o);
      end
   endtask

   task automatic test_credit_collision();
      bus.req_valid_i = 3'b010;
      tick();
      bus.req_valid_i   = 3'b000;
      bus.transmiting_i = 1'b1;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.credits_o !== 2'd1) begin
         errors++;
         $display("FAIL coll_setup: got valid=%0b credits=%0d expected 1 1",
                  bus.valid_o, bus.credits_o);
      end
      tick();
      bus.transmiting_i = 1'b0;
      tick();
      tick();
      bus.req_valid_i = 3'b010;
      #1;
      checks++;
      if (bus.req_ready_o !== 3'b010) begin
         errors++; $display("FAIL coll_grant: got %b expected 010", bus.req_ready_o);
      end
      tick();
      bus.req_valid_i = 3'b000;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.credits_o !== 2'd1) begin
         errors++;
         $display("FAIL coll_credits: got valid=%0b credits=%0d expected 1 1",
                  bus.valid_o, bus.credits_o);
      end
      return_credit();
      checks++;
      if (bus.credits_o !== 2'd2 || bus.err_o !== 1'b0) begin
         errors++;
         $display("FAIL coll_return: got credits=%0d err=%0b expected 2 0",
                  bus.credits_o, bus.err_o);
      end
      return_credit();
      checks++;
      if (bus.credits_o !== 2'd2 || bus.err_o !== 1'b1) begin
         errors++;
         $display("FAIL spurious_return: got credits=%0d err=%0b expected 2 1",
                  bus.credits_o, bus.err_o);
      end
   endtask

   task automatic test_disable_in_gap();
      logic activity = 1'b0;
      bus.req_valid_i = 3'b010;
      tick();
      checks++;
      if (bus.valid_o !== 1'b1) begin
         errors++; $display("FAIL dis_issue: got %0b expected 1", bus.valid_o);
      end
      bus.tx_enable_i = 1'b0;
      repeat (8) begin
         tick();
         activity |= (|bus.req_ready_o) | bus.valid_o;
      end
      checks++;
      if (activity !== 1'b0) begin
         errors++; $display("FAIL dis_activity: got %0b expected 0", activity);
      end
      checks++;
      if (dut.state_q !== DISABLED) begin
         errors++; $display("FAIL dis_state: got %0d expected %0d", dut.state_q, DISABLED);
      end
      checks++;
      if (bus.tx_idle_o !== 1'b0 || bus.credits_o !== 2'd1) begin
         errors++;
         $display("FAIL dis_pending: got idle=%0b credits=%0d expected 0 1",
                  bus.tx_idle_o, bus.credits_o);
      end
      return_credit();
      checks++;
      if (bus.tx_idle_o !== 1'b1 || bus.credits_o !== 2'd2) begin
         errors++;
         $display("FAIL dis_idle: got idle=%0b credits=%0d expected 1 2",
                  bus.tx_idle_o, bus.credits_o);
      end
   endtask

   task automatic test_reset_mid();
      int issues = 0;
      int cyc    = 0;
      bus.tx_enable_i = 1'b1;
      bus.req_valid_i = 3'b010;
      while (issues < 2 && cyc < 20) begin
         tick();
         cyc++;
         if (bus.valid_o) issues++;
      end
      checks++;
      if (issues != 2 || bus.credits_o !== 2'd0 || bus.err_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: got issues=%0d credits=%0d err=%0b expected 2 0 1",
                  issues, bus.credits_o, bus.err_o);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.credits_o !== 2'd2 || bus.err_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got valid=%0b credits=%0d err=%0b expected 0 2 0",
                  bus.valid_o, bus.credits_o, bus.err_o);
      end
      checks++;
      if (bus.flits_sent_o !== 16'd0 || bus.req_ready_o !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_counts: got flits=%0d ready=%b expected 0 000",
                  bus.flits_sent_o, bus.req_ready_o);
      end
   endtask

   initial begin
      bus.tx_enable_i   = 1'b0;
      bus.req_valid_i   = '0;
      bus.transmiting_i = 1'b0;
      for (int r = 0; r < 3; r++) bus.req_data_i[r] = flit_of(pat[r]);
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_single_issue();
      test_arbitration();
      test_credit_exhaust();
      test_credit_collision();
      test_disable_in_gap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
